eth_rx_filter: RTL

ETH_RX_FILTER -- requirements
Module: eth_rx_filter

---
 rtl/eth_rx_filter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_filter.sv
// Ethernet RX address filter: forwards station/broadcast/multicast/promiscuous frames, drops runts and misses; ETH_RX_FILTER_STATS_EN adds frame counters.
// Latency: one register stage, an accepted beat appears on m_axis one cycle after its s-side handshake.
// Backpressure: s_axis_tready follows the output stage; beats of dropped frames are always accepted and discarded.
module eth_rx_filter (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] s_axis_tdata,
    input  logic [15:0]  s_axis_tkeep,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    output logic [127:0] m_axis_tdata,
    output logic [15:0]  m_axis_tkeep,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic         m_axis_tfirst,
    output logic [47:0]  m_src_mac,
    output logic [15:0]  m_ethertype,
    input  logic [47:0]  cfg_mac,
    input  logic         cfg_promisc,
    input  logic         cfg_mcast_en,
    output logic [31:0]  stat_accept,
    output logic [31:0]  stat_drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          m_vld_q, m_vld_d;
    logic          m_first_q, m_first_d;
    logic          m_last_q, m_last_d;
    logic [127:0]  m_dat_q, m_dat_d;
    logic [15:0]   m_keep_q, m_keep_d;
    logic [47:0]   src_mac_q, src_mac_d;
    logic [15:0]   ethertype_q, ethertype_d;

    logic [47:0]   dst_mac;
    logic          is_first;
    logic          is_runt;
    logic          addr_hit;
    logic          first_acc;
    logic          discard;
    logic          out_free;
    logic          s_hs;
    logic          fwd_hs;

    // Frame decision is made combinationally on the first beat, so cfg_* only matters at that instant.
    always_comb begin
        dst_mac   = s_axis_tdata[47:0];
        is_first  = (state_q == IDLE);
        is_runt   = !s_axis_tkeep[13];
        addr_hit  = cfg_promisc
                  || (dst_mac == cfg_mac)
                  || (&dst_mac)
                  || (dst_mac[0] && cfg_mcast_en);
        first_acc = !is_runt && addr_hit;
        discard   = (state_q == DROP) || (is_first && !first_acc);
        out_free  = !m_vld_q || m_axis_tready;
        s_axis_tready = discard || out_free;
        s_hs      = s_axis_tvalid && s_axis_tready;
        fwd_hs    = s_hs && !discard;
    end

    always_comb begin
        state_d = state_q;
        if (s_hs) begin
            case (state_q)
                IDLE: begin
                    if (!s_axis_tlast) begin
                        state_d = first_acc ? FWD : DROP;
                    end
                end
                FWD, DROP: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        m_vld_d     = m_vld_q;
        m_first_d   = m_first_q;
        m_last_d    = m_last_q;
        m_dat_d     = m_dat_q;
        m_keep_d    = m_keep_q;
        src_mac_d   = src_mac_q;
        ethertype_d = ethertype_q;
        if (fwd_hs) begin
            m_vld_d   = 1'b1;
            m_first_d = is_first;
            m_last_d  = s_axis_tlast;
            m_dat_d   = s_axis_tdata;
            m_keep_d  = s_axis_tkeep;
        end else if (m_axis_tready) begin
            m_vld_d   = 1'b0;
        end
        // Header only follows forwarded frames so a dropped frame never disturbs a stalled first beat.
        if (fwd_hs && is_first) begin
            src_mac_d   = s_axis_tdata[95:48];
            ethertype_d = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_vld_q     <= 1'b0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_dat_q     <= '0;
            m_keep_q    <= '0;
            src_mac_q   <= '0;
            ethertype_q <= '0;
        end else begin
            state_q     <= state_d;
            m_vld_q     <= m_vld_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            m_dat_q     <= m_dat_d;
            m_keep_q    <= m_keep_d;
            src_mac_q   <= src_mac_d;
            ethertype_q <= ethertype_d;
        end
    end

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tfirst = m_first_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_src_mac     = src_mac_q;
    assign m_ethertype   = ethertype_q;

`ifdef ETH_RX_FILTER_STATS_EN
    logic [31:0] stat_accept_q, stat_accept_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    // One count per frame, taken on its first beat; both counters saturate.
    always_comb begin
        stat_accept_d = stat_accept_q;
        stat_drop_d   = stat_drop_q;
        if (s_hs && is_first) begin
            if (first_acc) begin
                if (stat_accept_q != 32'hFFFF_FFFF) begin
                    stat_accept_d = stat_accept_q + 32'd1;
                end
            end else begin
                if (stat_drop_q != 32'hFFFF_FFFF) begin
                    stat_drop_d = stat_drop_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accept_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_drop_q   <= stat_drop_d;
        end
    end

    assign stat_accept = stat_accept_q;
    assign stat_drop   = stat_drop_q;
`else
    assign stat_accept = 32'd0;
    assign stat_drop   = 32'd0;
`endif

endmodule
